// File: rtl/servo_motion_sequencer_pkg.sv
// servo_motion_sequencer_pkg: shared state encoding, motion defaults and frame length derivation
package servo_motion_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;
   localparam int COORD_MAX_DEF = 270;
   localparam int HOME_POS_DEF = 90;
   function automatic int frame_len(input int freq, input int target_freq);
      return freq / target_freq;
   endfunction
endpackage

// File: rtl/servo_motion_sequencer_frame_tick_gen.sv
// frame_tick_gen: free-running frame timer, tick pulses on the last cycle of each frame
module frame_tick_gen
   import servo_motion_sequencer_pkg::*;
#(
   parameter int FREQ = 25_000_000,
   parameter int TARGET_FREQ = 50
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int FL = frame_len(FREQ, TARGET_FREQ);
   localparam int CW = FL > 1 ? $clog2(FL) : 1;
   localparam logic [CW-1:0] LAST = CW'(FL - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic tick_q, tick_d;
   always_comb begin
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      tick_d = cnt_d == LAST;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tick_q <= tick_d;
      end
   end
   assign tick = tick_q;
endmodule

// File: rtl/servo_motion_sequencer.sv
// servo_motion_sequencer: clamps x/y/z targets and rate-limits servo positions once per PWM frame
module servo_motion_sequencer
   import servo_motion_sequencer_pkg::*;
#(
   parameter int FREQ = 25_000_000,
   parameter int TARGET_FREQ = 50,
   parameter int BIT_SIZE = 10,
   parameter int COORD_MAX = COORD_MAX_DEF,
   parameter int HOME_POS = HOME_POS_DEF,
   parameter int STEP_DEG = 10,
   parameter int SETTLE_FRAMES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic signed [BIT_SIZE-1:0] tgt_x,
   input  logic signed [BIT_SIZE-1:0] tgt_y,
   input  logic signed [BIT_SIZE-1:0] tgt_z,
   input  logic                       stop,
   output logic signed [BIT_SIZE-1:0] pos_x,
   output logic signed [BIT_SIZE-1:0] pos_y,
   output logic signed [BIT_SIZE-1:0] pos_z,
   output logic                       busy,
   output logic                       done,
   output logic                       aborted,
   output logic                       frame_tick
);
   localparam int SW = $clog2(SETTLE_FRAMES + 2);
   localparam int EW = BIT_SIZE + 2;
   typedef logic signed [BIT_SIZE-1:0] ang_t;
   localparam ang_t CMAX = ang_t'(COORD_MAX);
   localparam ang_t HOME = ang_t'(HOME_POS);
   localparam ang_t STEP = ang_t'(STEP_DEG);
   localparam logic signed [EW-1:0] STEP_W = EW'(STEP_DEG);
   function automatic ang_t clamp(input ang_t v);
      return v > CMAX ? CMAX : (v < -CMAX ? -CMAX : v);
   endfunction
   function automatic ang_t step_axis(input ang_t pos, input ang_t tgt);
      logic signed [EW-1:0] d;
      d = {{2{tgt[BIT_SIZE-1]}}, tgt} - {{2{pos[BIT_SIZE-1]}}, pos};
      return (d <= STEP_W && d >= -STEP_W) ? tgt : (d[EW-1] ? pos - STEP : pos + STEP);
   endfunction
   state_t state_q, state_d;
   ang_t pos_q[3], pos_d[3], tgt_q[3], tgt_d[3], tgt_in[3];
   logic [SW-1:0] settle_q, settle_d;
   logic done_q, done_d, aborted_q, aborted_d, at_tgt;
   frame_tick_gen #(.FREQ(FREQ), .TARGET_FREQ(TARGET_FREQ)) u_frame (
      .clk(clk),
      .rst(rst),
      .tick(frame_tick)
   );
   assign tgt_in = '{tgt_x, tgt_y, tgt_z};
   assign at_tgt = pos_q[0] == tgt_q[0] && pos_q[1] == tgt_q[1] && pos_q[2] == tgt_q[2];
   always_comb begin
      state_d = state_q;
      pos_d = pos_q;
      tgt_d = tgt_q;
      settle_d = settle_q;
      done_d = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               for (int i = 0; i < 3; i++) tgt_d[i] = clamp(tgt_in[i]);
               state_d = MOVE;
            end
         end
         MOVE: begin
            if (stop) begin
               state_d = IDLE;
               aborted_d = 1'b1;
            end else if (at_tgt) begin
               state_d = SETTLE;
               settle_d = SW'(SETTLE_FRAMES);
            end else if (frame_tick) begin
               for (int i = 0; i < 3; i++) pos_d[i] = step_axis(pos_q[i], tgt_q[i]);
            end
         end
         SETTLE: begin
            if (stop) begin
               state_d = IDLE;
               aborted_d = 1'b1;
            end else if (settle_q == '0) begin
               state_d = IDLE;
               done_d = 1'b1;
            end else if (frame_tick) begin
               settle_d = settle_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         for (int i = 0; i < 3; i++) begin
            pos_q[i] <= HOME;
            tgt_q[i] <= HOME;
         end
         settle_q <= '0;
         done_q <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q <= pos_d;
         tgt_q <= tgt_d;
         settle_q <= settle_d;
         done_q <= done_d;
         aborted_q <= aborted_d;
      end
   end
   assign cmd_ready = state_q == IDLE;
   assign busy = state_q != IDLE;
   assign done = done_q;
   assign aborted = aborted_q;
   assign pos_x = pos_q[0];
   assign pos_y = pos_q[1];
   assign pos_z = pos_q[2];
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// tb_servo_motion_sequencer: directed and random stimulus against a behavioural motion model
module tb_servo_motion_sequencer;
   localparam int FL = 10;
   localparam int STEP = 10;
   localparam int SETTLE = 2;
   localparam int CMAX = 270;
   localparam int HOME = 90;
   logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, stop = 1'b0;
   logic signed [9:0] tgt_x = '0, tgt_y = '0, tgt_z = '0;
   logic signed [9:0] pos_x, pos_y, pos_z;
   logic cmd_ready, busy, done, aborted, frame_tick;
   int pass_cnt = 0, total_cnt = 0, done_seen = 0;
   bit chk_en = 1'b0;
   int m_pos[3] = '{HOME, HOME, HOME};
   int m_tgt[3] = '{HOME, HOME, HOME};
   int m_ph = 0, m_settle = 0, m_cnt = 0;
   bit m_done = 1'b0, m_abort = 1'b0;
   servo_motion_sequencer #(
      .FREQ(100), .TARGET_FREQ(10), .BIT_SIZE(10), .COORD_MAX(CMAX),
      .HOME_POS(HOME), .STEP_DEG(STEP), .SETTLE_FRAMES(SETTLE)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_z(tgt_z), .stop(stop),
      .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z), .busy(busy),
      .done(done), .aborted(aborted), .frame_tick(frame_tick)
   );
   always #5 clk = ~clk;
   function automatic int clampi(input int v);
      return v > CMAX ? CMAX : (v < -CMAX ? -CMAX : v);
   endfunction
   function automatic int movei(input int p, input int t);
      int d;
      d = t - p;
      d = d > STEP ? STEP : (d < -STEP ? -STEP : d);
      return p + d;
   endfunction
   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask
   // phase 0 idle, 1 moving, 2 settling
   always @(posedge clk) begin : model
      if (rst) begin
         m_pos <= '{HOME, HOME, HOME};
         m_ph <= 0;
         m_settle <= 0;
         m_cnt <= 0;
         m_done <= 1'b0;
         m_abort <= 1'b0;
      end else begin
         m_cnt <= (m_cnt + 1) % FL;
         m_done <= 1'b0;
         m_abort <= 1'b0;
         if (m_ph == 0) begin
            if (cmd_valid) begin
               m_tgt <= '{clampi(int'(tgt_x)), clampi(int'(tgt_y)), clampi(int'(tgt_z))};
               m_ph <= 1;
            end
         end else if (stop) begin
            m_ph <= 0;
            m_abort <= 1'b1;
         end else if (m_ph == 1) begin
            if (m_pos[0] == m_tgt[0] && m_pos[1] == m_tgt[1] && m_pos[2] == m_tgt[2]) begin
               m_ph <= 2;
               m_settle <= SETTLE;
            end else if (m_cnt == FL - 1) begin
               for (int i = 0; i < 3; i++) m_pos[i] <= movei(m_pos[i], m_tgt[i]);
            end
         end else if (m_settle == 0) begin
            m_ph <= 0;
            m_done <= 1'b1;
         end else if (m_cnt == FL - 1) begin
            m_settle <= m_settle - 1;
         end
      end
   end
   always @(negedge clk) begin
      if (chk_en) begin
         check("pos_x", pos_x, m_pos[0]);
         check("pos_y", pos_y, m_pos[1]);
         check("pos_z", pos_z, m_pos[2]);
         check("frame_tick", frame_tick, int'(m_cnt == FL - 1));
         check("busy", busy, int'(m_ph != 0));
         check("cmd_ready", cmd_ready, int'(m_ph == 0));
         check("done", done, m_done);
         check("aborted", aborted, m_abort);
         if (done) done_seen++;
      end
   end
   task automatic send(input int x, input int y, input int z);
      cmd_valid = 1'b1;
      tgt_x = 10'(x);
      tgt_y = 10'(y);
      tgt_z = 10'(z);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask
   task automatic next_tick();
      do @(negedge clk); while (m_cnt != FL - 1);
      @(posedge clk); #1;
   endtask
   task automatic wait_done(input int lim);
      bit ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_done", ok, 1);
      @(posedge clk); #1;
   endtask
   task automatic go_home();
      send(HOME, HOME, HOME);
      wait_done(600);
   endtask
   task automatic first_tick_index(output int idx);
      idx = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (frame_tick) begin
            idx = i;
            break;
         end
      end
      @(posedge clk); #1;
   endtask
   task automatic settle_done_check(input string name);
      next_tick();
      next_tick();
      @(negedge clk);
      check({name, "_done_early"}, done, 0);
      @(negedge clk);
      check({name, "_done"}, done, 1);
      @(posedge clk); #1;
      check({name, "_ready_after"}, cmd_ready, 1);
   endtask
   initial begin
      int idx, tx, ty, d0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      first_tick_index(idx);
      check("reset_tick_idx", idx, 9);
      check("reset_pos_x", pos_x, 90);
      check("reset_pos_z", pos_z, 90);
      check("reset_ready", cmd_ready, 1);
      check("reset_busy", busy, 0);
      send(95, 90, 90);
      next_tick();
      check("partial_pos_x", pos_x, 95);
      settle_done_check("partial");
      go_home();
      d0 = done_seen;
      send(130, 90, 60);
      next_tick();
      check("s2_x1", pos_x, 100);
      check("s2_z1", pos_z, 80);
      next_tick();
      check("s2_x2", pos_x, 110);
      check("s2_z2", pos_z, 70);
      next_tick();
      check("s2_x3", pos_x, 120);
      check("s2_z3", pos_z, 60);
      next_tick();
      check("s2_x4", pos_x, 130);
      check("s2_z4", pos_z, 60);
      check("s2_y4", pos_y, 90);
      settle_done_check("s2");
      check("s2_done_once", done_seen - d0, 1);
      go_home();
      send(400, -300, 90);
      tx = 0;
      ty = 0;
      for (int t = 1; t <= 45 && (tx == 0 || ty == 0); t++) begin
         next_tick();
         if (tx == 0 && pos_x == 270) tx = t;
         if (ty == 0 && pos_y == -270) ty = t;
      end
      check("clamp_x_ticks", tx, 18);
      check("clamp_y_ticks", ty, 36);
      wait_done(100);
      go_home();
      d0 = done_seen;
      send(200, 90, 90);
      next_tick();
      cmd_valid = 1'b1;
      tgt_x = -10'sd100;
      repeat (3) @(posedge clk);
      #1 cmd_valid = 1'b0;
      next_tick();
      check("stop_pre_x", pos_x, 110);
      do @(negedge clk); while (m_cnt != FL - 2);
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      @(negedge clk);
      check("stop_aborted", aborted, 1);
      check("stop_hold_x", pos_x, 110);
      check("stop_busy", busy, 0);
      @(negedge clk);
      check("stop_aborted_pulse", aborted, 0);
      check("stop_no_done", done_seen - d0, 0);
      @(posedge clk); #1;
      go_home();
      send(200, 90, 90);
      next_tick();
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      first_tick_index(idx);
      check("rst_mid_tick_idx", idx, 9);
      check("rst_mid_pos_x", pos_x, 90);
      check("rst_mid_busy", busy, 0);
      send(60, 90, 90);
      wait_done(200);
      check("rst_mid_final_x", pos_x, 60);
      for (int c = 0; c < 4000; c++) begin
         cmd_valid = ($urandom % 3) == 0;
         tgt_x = 10'($urandom_range(0, 800) - 400);
         tgt_y = 10'($urandom_range(0, 800) - 400);
         tgt_z = 10'($urandom_range(0, 800) - 400);
         stop = ($urandom % 150) == 0;
         rst = ($urandom % 500) == 0;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      stop = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule

// File: doc/servo_motion_sequencer.md
Name: servo_motion_sequencer

Overview:
Motion controller placed upstream of the three-servo PWM generator. It accepts one target (x, y, z) angle command per handshake and clamps each target to the legal range. It then moves the commanded position toward the target by at most STEP_DEG per axis per PWM frame, so servo moves are rate-limited. After arrival it holds for a fixed number of settle frames, then signals completion. Its pos_x/pos_y/pos_z outputs drive the x/y/z inputs of the PWM block directly.

Parameters:
FREQ, 25_000_000, system clock frequency in Hz
TARGET_FREQ, 50, PWM frame rate in Hz; FRAME_LEN = FREQ/TARGET_FREQ clock cycles
BIT_SIZE, 10, width of signed angle ports
COORD_MAX, 270, target clamp magnitude; legal range is -COORD_MAX..+COORD_MAX
HOME_POS, 90, reset position of every axis
STEP_DEG, 10, maximum per-axis move per frame tick (>=1)
SETTLE_FRAMES, 2, frame ticks to hold after arrival before done (0 allowed)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  target command valid
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
tgt_x, tgt_y, tgt_z  in  BIT_SIZE signed  requested angles
stop  in  1  abort current move; hold at current position
pos_x, pos_y, pos_z  out  BIT_SIZE signed  commanded angles to the PWM block
busy  out  1  high in MOVE or SETTLE
done  out  1  1-cycle pulse on normal completion
aborted  out  1  1-cycle pulse when stop ends a move
frame_tick  out  1  1-cycle pulse at each frame boundary

Behaviour:
- Reset: one clock, synchronous active-high; reset is sampled on the rising edge of clk and the polarity and synchronicity are fixed. On reset: pos_* = HOME_POS, state = IDLE, frame counter = 0, settle counter = 0, done/aborted/frame_tick = 0, busy = 0, cmd_ready = 1. Reset mid-move discards the target.
- Frame timer: free-running, counts 0..FRAME_LEN-1 and wraps. frame_tick = 1 in the cycle where the count equals FRAME_LEN-1. The timer is never restarted by commands.
- States: IDLE, MOVE, SETTLE.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid && cmd_ready, each tgt_* is clamped to ±COORD_MAX and registered, and the next state is MOVE.
  - stop is ignored in IDLE, including when it coincides with command acceptance.
- MOVE:
  - On a frame_tick, for each axis: d = tgt - pos, computed at BIT_SIZE+2 signed width.
    - If |d| <= STEP_DEG: pos <= tgt.
    - Else: pos <= pos + sign(d)*STEP_DEG.
  - All three axes update in the same cycle.
  - When all pos == tgt (checked on registered values), the next state is SETTLE and the settle counter loads SETTLE_FRAMES. This check does not wait for a tick, so a command equal to the current position enters SETTLE one cycle after acceptance.
- SETTLE:
  - The settle counter decrements on each frame_tick.
  - When the counter is 0, the next state is IDLE and done pulses in that transition cycle.
  - With SETTLE_FRAMES = 0, done pulses in the cycle after entering SETTLE.
- Stop in MOVE or SETTLE: the next state is IDLE, pos_* hold their current values, aborted pulses for 1 cycle, and done is not asserted. Stop has priority over a same-cycle position update; that tick's step is not applied.
- cmd_valid while busy: ignored. No command queue.
- pos_* change only on frame_tick cycles, so the PWM block sees new values at most once per frame.
- Outputs are registered except cmd_ready and busy, which are state decodes.

Decomposition:
- Shared package: state encoding (IDLE/MOVE/SETTLE), COORD_MAX/HOME_POS defaults, and the FRAME_LEN derivation. The PWM block uses the same constants.
- One sub-module, frame_tick_gen (parameters FREQ and TARGET_FREQ; outputs tick). It is reusable by the PWM block for period alignment.
- The per-axis step logic is a function, instantiated three times.

Test Plan:
All scenarios use FREQ=100, TARGET_FREQ=10 (FRAME_LEN=10), STEP_DEG=10, SETTLE_FRAMES=2.
1. Reset -> pos_x/y/z = 90, cmd_ready = 1, busy = 0, frame_tick pulses every 10 cycles (cycle 9 after reset release).
2. cmd (130, 90, 60) -> pos_x 100, 110, 120, 130 over 4 ticks; pos_z 80, 70, 60 over 3 ticks; pos_y constant 90; done pulses once, 2 ticks after pos_x reaches 130; cmd_ready returns to 1.
3. cmd (95, 90, 90) from home -> pos_x = 95 after first tick (partial step); done after 2 further ticks.
4. cmd (400, -300, 90) -> registered targets 270 / -270; pos_x reaches 270 after 18 ticks, pos_y reaches -270 after 36 ticks.
5. cmd (200, 90, 90), stop asserted coincident with the third tick -> pos_x holds at 110 (third step not applied), aborted pulses for 1 cycle, done stays 0, state IDLE; cmd_valid during the earlier move was ignored.
6. rst pulsed mid-move -> next cycle pos_* = 90, busy = 0, frame counter restarts at 0; a new command then completes normally.
